// File: rtl/cpu_seq_gen_if.sv
// Decoder/bus-side signal bundle of the machine-cycle / T-state sequencer.
// master = the sequencer itself, slave = the decoder and bus logic around it.
interface cpu_seq_gen_if #(
    parameter int MAX_CYC = 3,
    parameter int CYC_W   = 2
);
    // Handshake: a T-state transition happens on a clock with STEP_I=1; READY_I
    // is the memory/IO ready, only meaningful while STATE_O is T2 or WAIT.
    logic               STEP_I;
    logic               READY_I;
    logic               INT_I;
    logic               HLT_I;
    logic [CYC_W-1:0]   NCYC_I;
    logic [MAX_CYC-1:0] LONG_I;
    logic               SKIP_I;
    logic [2:0]         STATE_O;
    logic [CYC_W-1:0]   CYCLE_O;
    logic               INTA_O;
    logic               DONE_O;

    modport master (
        input  STEP_I, READY_I, INT_I, HLT_I, NCYC_I, LONG_I, SKIP_I,
        output STATE_O, CYCLE_O, INTA_O, DONE_O
    );

    modport slave (
        output STEP_I, READY_I, INT_I, HLT_I, NCYC_I, LONG_I, SKIP_I,
        input  STATE_O, CYCLE_O, INTA_O, DONE_O
    );
endinterface

// File: rtl/cpu_seq_gen.sv
// Parametrised MCS8 machine-cycle / T-state sequencer driven by a per-instruction
// cycle descriptor latched at cycle-0 T3; STATE_O doubles as the FSM debug view.
module cpu_seq_gen #(
    parameter int MAX_CYC   = 3,
    parameter int CYC_W     = 2,
    parameter int AUTO_WAIT = 0
) (
    input logic          CLK_I,
    input logic          RST_I,
    cpu_seq_gen_if.master bus
);
    typedef enum logic [2:0] {
        S_T1   = 3'b010,
        S_T1I  = 3'b110,
        S_T2   = 3'b100,
        S_WAIT = 3'b000,
        S_T3   = 3'b001,
        S_STOP = 3'b011,
        S_T4   = 3'b111,
        S_T5   = 3'b101
    } state_e;

    localparam logic [CYC_W-1:0] MAXC = CYC_W'(MAX_CYC);
    localparam logic [2:0]       AW   = 3'(AUTO_WAIT);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic               inta_q, inta_d;
    logic               done_q, done_d;
    logic [CYC_W-1:0]   ncyc_q, ncyc_d;
    logic [MAX_CYC-1:0] long_q, long_d;
    logic [2:0]         wait_q, wait_d;
    logic [CYC_W-1:0]   ncyc_in;
    logic               last_cyc;
    logic               end_instr;

    // Descriptor cycle count as it will be latched: 0 means 1, clamp to MAX_CYC.
    always_comb begin
        ncyc_in = bus.NCYC_I;
        if (bus.NCYC_I == '0)
            ncyc_in = CYC_W'(1);
        else if (int'(bus.NCYC_I) > MAX_CYC)
            ncyc_in = MAXC;
    end

    assign last_cyc = (cycle_q == (ncyc_q - CYC_W'(1)));

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        inta_d    = inta_q;
        done_d    = 1'b0;
        ncyc_d    = ncyc_q;
        long_d    = long_q;
        wait_d    = wait_q;
        end_instr = 1'b0;
        if (bus.STEP_I) begin
            if (cycle_q >= MAXC) begin
                state_d = S_T1;
                cycle_d = '0;
            end else begin
                case (state_q)
                    S_T1, S_T1I: state_d = S_T2;
                    S_T2: begin
                        if (AUTO_WAIT > 0 || !bus.READY_I) begin
                            state_d = S_WAIT;
                            wait_d  = AW;
                        end else begin
                            state_d = S_T3;
                        end
                    end
                    S_WAIT: begin
                        // Leave once the count reaches zero on this step and ready is up.
                        if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
                        if (wait_q <= 3'd1 && bus.READY_I) state_d = S_T3;
                    end
                    S_T3: begin
                        if (cycle_q == '0) begin
                            ncyc_d = ncyc_in;
                            long_d = bus.LONG_I;
                            inta_d = 1'b0;
                            if (bus.HLT_I) begin
                                state_d = S_STOP;
                                done_d  = 1'b1;
                            end else if (bus.LONG_I[0]) begin
                                state_d = S_T4;
                            end else if (ncyc_in == CYC_W'(1)) begin
                                end_instr = 1'b1;
                            end else begin
                                state_d = S_T1;
                                cycle_d = CYC_W'(1);
                            end
                        end else if (bus.SKIP_I) begin
                            end_instr = 1'b1;
                        end else if (long_q[cycle_q]) begin
                            state_d = S_T4;
                        end else if (last_cyc) begin
                            end_instr = 1'b1;
                        end else begin
                            state_d = S_T1;
                            cycle_d = cycle_q + CYC_W'(1);
                        end
                    end
                    S_T4: state_d = S_T5;
                    S_T5: begin
                        if (last_cyc) begin
                            end_instr = 1'b1;
                        end else begin
                            state_d = S_T1;
                            cycle_d = cycle_q + CYC_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (bus.INT_I) begin
                            state_d = S_T1I;
                            cycle_d = '0;
                            inta_d  = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_T1;
                        cycle_d = '0;
                    end
                endcase
            end
            if (end_instr) begin
                cycle_d = '0;
                done_d  = 1'b1;
                state_d = bus.INT_I ? S_T1I : S_T1;
                inta_d  = bus.INT_I;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= S_T1;
            cycle_q <= '0;
            inta_q  <= 1'b0;
            done_q  <= 1'b0;
            ncyc_q  <= CYC_W'(1);
            long_q  <= '0;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            inta_q  <= inta_d;
            done_q  <= done_d;
            ncyc_q  <= ncyc_d;
            long_q  <= long_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.STATE_O = state_q;
    assign bus.CYCLE_O = cycle_q;
    assign bus.INTA_O  = inta_q;
    assign bus.DONE_O  = done_q;
endmodule

// File: tb/tb_cpu_seq_gen.sv
// Bench for cpu_seq_gen: builds the expected T-state trace of each instruction
// from its descriptor and compares the sequencer outputs clock by clock.
module tb_cpu_seq_gen;
  localparam int MAX_CYC = 3;
  localparam int CYC_W   = 2;
  localparam logic [2:0] T1 = 3'b010, T1I = 3'b110, T2 = 3'b100, TW = 3'b000;
  localparam logic [2:0] T3 = 3'b001, STOP = 3'b011, T4 = 3'b111, T5 = 3'b101;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cyc;
    logic       inta;
    logic       rdy_drv;
    logic       rdy;
    logic [1:0] term;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic step = 1'b0, ready = 1'b0, intr = 1'b0, hlt = 1'b0, skip = 1'b0;
  logic [CYC_W-1:0]   ncyc = '0;
  logic [MAX_CYC-1:0] lng = '0;

  cpu_seq_gen_if #(.MAX_CYC(MAX_CYC), .CYC_W(CYC_W)) if0 ();
  cpu_seq_gen_if #(.MAX_CYC(MAX_CYC), .CYC_W(CYC_W)) if2 ();

  assign if0.STEP_I = step;  assign if2.STEP_I = step;
  assign if0.READY_I = ready; assign if2.READY_I = ready;
  assign if0.INT_I = intr;   assign if2.INT_I = intr;
  assign if0.HLT_I = hlt;    assign if2.HLT_I = hlt;
  assign if0.NCYC_I = ncyc;  assign if2.NCYC_I = ncyc;
  assign if0.LONG_I = lng;   assign if2.LONG_I = lng;
  assign if0.SKIP_I = skip;  assign if2.SKIP_I = skip;

  cpu_seq_gen #(.MAX_CYC(MAX_CYC), .CYC_W(CYC_W), .AUTO_WAIT(0)) dut0 (
    .CLK_I(clk), .RST_I(rst | sel), .bus(if0.master));
  cpu_seq_gen #(.MAX_CYC(MAX_CYC), .CYC_W(CYC_W), .AUTO_WAIT(2)) dut2 (
    .CLK_I(clk), .RST_I(rst | ~sel), .bus(if2.master));

  logic [2:0]       st_o;
  logic [CYC_W-1:0] cy_o;
  logic             ia_o, dn_o;
  assign st_o = sel ? if2.STATE_O : if0.STATE_O;
  assign cy_o = sel ? if2.CYCLE_O : if0.CYCLE_O;
  assign ia_o = sel ? if2.INTA_O  : if0.INTA_O;
  assign dn_o = sel ? if2.DONE_O  : if0.DONE_O;

  int checks = 0;
  int failures = 0;
  int aw = 0;
  int step_mode = 0;
  logic step_tog = 1'b0;
  logic [2:0] first_st = T1;
  logic exp_done = 1'b0;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input ent_t e);
    chk("state", 32'(st_o), 32'(e.st));
    chk("cycle", 32'(cy_o), 32'(e.cyc));
    chk("inta", 32'(ia_o), 32'(e.inta));
    chk("done", 32'(dn_o), 32'(exp_done));
  endtask

  // driver tasks
  task automatic get_step(output logic s);
    if (step_mode == 0) s = 1'b1;
    else if (step_mode == 1) begin
      step_tog = ~step_tog;
      s = step_tog;
    end else s = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    ent_t e;
    rst = 1'b1;
    step = 1'b0;
    repeat (2) @(negedge clk);
    exp_done = 1'b0;
    e = '0;
    e.st = T1;
    check_out(e);
    rst = 1'b0;
    first_st = T1;
  endtask

  // rw holds 4-bit READY-low step counts per machine cycle, starting at T2.
  task automatic run_instr(input int n_raw, input int lg, input bit h, input bit sk,
                           input bit ie, input logic [11:0] rw, input int stop_len,
                           input int rst_at);
    ent_t q[$];
    ent_t e;
    int n, nw, r, idx, cnt;
    logic s;
    logic [1:0] last_term;
    n = (n_raw == 0) ? 1 : ((n_raw > MAX_CYC) ? MAX_CYC : n_raw);
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.cyc = k[1:0];
      e.inta = (k == 0) && (first_st == T1I);
      e.st = (k == 0) ? first_st : T1;
      q.push_back(e);
      r = int'(rw[k*4 +: 4]);
      nw = (r > aw) ? r : aw;
      for (int w = 0; w <= nw; w++) begin
        e.st = (w == 0) ? T2 : TW;
        e.rdy_drv = 1'b1;
        e.rdy = (w >= r);
        q.push_back(e);
      end
      e.rdy_drv = 1'b0;
      e.rdy = 1'b0;
      e.st = T3;
      if (k == 0 && h) begin
        e.term = 2'd2;
        q.push_back(e);
        break;
      end
      if (k > 0 && sk) begin
        e.term = 2'd1;
        q.push_back(e);
        break;
      end
      if (lg[k]) begin
        q.push_back(e);
        e.inta = 1'b0;
        e.st = T4;
        q.push_back(e);
        e.st = T5;
        e.term = (k == n - 1) ? 2'd1 : 2'd0;
        q.push_back(e);
      end else begin
        e.term = (k == n - 1) ? 2'd1 : 2'd0;
        q.push_back(e);
      end
    end

    idx = 0;
    last_term = 2'd0;
    while (q.size() > 0) begin
      e = q.pop_front();
      do begin
        check_out(e);
        get_step(s);
        step = s;
        ready = e.rdy_drv ? e.rdy : 1'($urandom_range(0, 1));
        if (e.st == T3 && e.cyc == 2'd0) begin
          ncyc = n_raw[1:0];
          lng = lg[2:0];
          hlt = h;
          skip = 1'($urandom_range(0, 1));
        end else begin
          ncyc = CYC_W'($urandom_range(0, 3));
          lng = MAX_CYC'($urandom_range(0, 7));
          hlt = 1'($urandom_range(0, 1));
          skip = (e.st == T3) ? sk : 1'($urandom_range(0, 1));
        end
        intr = (e.term == 2'd1) ? ie : 1'($urandom_range(0, 1));
        if (idx == rst_at) begin
          rst = 1'b1;
          intr = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          exp_done = 1'b0;
          first_st = T1;
          return;
        end
        @(negedge clk);
        exp_done = s && (e.term != 2'd0);
      end while (!s);
      last_term = e.term;
      idx++;
    end

    if (last_term == 2'd1) first_st = ie ? T1I : T1;
    if (h) begin
      e = '0;
      e.st = STOP;
      cnt = 0;
      while (1) begin
        check_out(e);
        get_step(s);
        step = s;
        intr = (cnt >= stop_len);
        ready = 1'($urandom_range(0, 1));
        hlt = 1'($urandom_range(0, 1));
        skip = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_done = 1'b0;
        if (s) begin
          if (intr) break;
          cnt++;
        end
      end
      first_st = T1I;
    end
  endtask

  task automatic rand_instr();
    logic [11:0] rw;
    for (int k = 0; k < 3; k++)
      rw[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 4)) : 4'd0;
    run_instr($urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rw,
              $urandom_range(0, 4), -1);
  endtask

  initial begin
    do_reset();
    step_mode = 0;
    repeat (3) run_instr(1, 0, 0, 0, 0, 12'h000, 0, -1);
    run_instr(3, 3'b100, 0, 0, 0, 12'h000, 0, -1);
    run_instr(1, 0, 0, 0, 0, 12'h004, 0, -1);
    run_instr(1, 0, 1, 0, 0, 12'h000, 10, -1);
    run_instr(2, 3'b001, 0, 0, 0, 12'h000, 0, -1);
    run_instr(3, 0, 0, 1, 0, 12'h000, 0, -1);
    run_instr(2, 0, 1, 0, 1, 12'h000, 0, -1);
    run_instr(0, 0, 0, 0, 1, 12'h000, 0, -1);
    step_mode = 1;
    run_instr(2, 3'b010, 0, 0, 0, 12'h021, 0, -1);
    run_instr(1, 0, 1, 0, 0, 12'h000, 3, -1);
    step_mode = 0;
    run_instr(3, 3'b100, 0, 0, 0, 12'h000, 0, 9);
    run_instr(1, 0, 0, 0, 0, 12'h000, 0, -1);
    step_mode = 2;
    repeat (40) rand_instr();

    sel = 1'b1;
    aw = 2;
    do_reset();
    step_mode = 0;
    run_instr(2, 0, 0, 0, 0, 12'h000, 0, -1);
    run_instr(1, 3'b001, 0, 0, 0, 12'h003, 0, -1);
    run_instr(3, 3'b010, 0, 0, 1, 12'h310, 0, -1);
    step_mode = 2;
    repeat (20) rand_instr();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_seq_gen.md
# cpu_seq_gen

Parametrised machine-cycle / T-state sequencer for the MCS8 core family. It generalises the fixed 8008 cycle/state machine in four ways. The decoder supplies a per-instruction cycle descriptor instead of individual opcode flags. The maximum machine-cycle count is a parameter. Programmable forced wait states are inserted after T2. A single-clock step enable replaces the two-phase clock. It sits between the instruction decoder and the bus/datapath control, which key off STATE_O/CYCLE_O.

## Interface
- MAX_CYC, 3, maximum machine cycles per instruction (2..4)
- CYC_W, 2, width of CYCLE_O and NCYC_I; must hold MAX_CYC
- AUTO_WAIT, 0, forced WAIT states inserted after every T2 (0..7)

- CLK_I  in  1  single clock; all state changes on rising edge
- RST_I  in  1  reset, synchronous, active-high
- STEP_I  in  1  advance enable; one T-state transition per clock with STEP_I=1
- READY_I  in  1  memory/IO ready; sampled in T2 and WAIT
- INT_I  in  1  interrupt request; sampled at instruction end and in STOP
- HLT_I  in  1  halt decode; sampled at cycle-0 T3
- NCYC_I  in  CYC_W  machine cycles of current instruction; sampled at cycle-0 T3
- LONG_I  in  MAX_CYC  bit k=1: cycle k runs T4,T5 after T3; sampled at cycle-0 T3
- SKIP_I  in  1  condition-false early exit; sampled at T3 of cycles ≥1
- STATE_O  out  3  T-state: T1=010, T1I=110, T2=100, WAIT=000, T3=001, STOP=011, T4=111, T5=101
- CYCLE_O  out  CYC_W  current machine cycle, 0-based
- INTA_O  out  1  interrupt-acknowledge instruction in cycle 0
- DONE_O  out  1  one-clock pulse: instruction ended

## Operation
- Reset values: STATE_O=T1, CYCLE_O=0, INTA_O=0, DONE_O=0. Latched descriptor: ncyc=1, long=0. Wait counter=0.
- STEP_I=0: all state, counters and latches hold. DONE_O still self-clears.
- T1, T1I → T2.
- T2 → WAIT if AUTO_WAIT>0 or READY_I=0, else T3. Entering WAIT loads the counter with AUTO_WAIT.
- WAIT: the counter decrements per step while nonzero. Exit to T3 on the step where counter==0 and READY_I=1; otherwise stay in WAIT.
- T3, cycle 0: latch NCYC_I (0 treated as 1; >MAX_CYC clamped to MAX_CYC), LONG_I and HLT_I. HLT_I=1 → STOP and end instruction. SKIP_I is ignored in cycle 0.
- T3, otherwise, evaluated in priority order:
  - SKIP_I=1 (cycle≥1) → end instruction.
  - long[cycle]=1 → T4.
  - cycle==ncyc-1 → end instruction.
  - else → T1 with cycle+1.
- T4 → T5.
- T5: cycle==ncyc-1 → end instruction; else T1 with cycle+1.
- End instruction (except HLT): CYCLE_O→0; next state T1I if INT_I=1, else T1. DONE_O=1 on the following clock.
- HLT at cycle-0 T3: DONE_O pulses and STATE_O→STOP. STOP holds until a step with INT_I=1 → T1I, cycle 0.
- INTA_O: set on entry to T1I; cleared on the step leaving cycle-0 T3.
- HLT and INT both set at cycle-0 T3: HLT wins. INT is then seen in STOP on the next step.
- Unencoded STATE_O value, or CYCLE_O≥MAX_CYC → T1, cycle 0 on the next step.
- Reset mid-instruction (any state, including WAIT or STOP): next clock shows reset values. Pending INT is not remembered.

## Timing
- All outputs registered; STATE_O/CYCLE_O change one clock after the enabling step.
- STEP_I=1, READY_I=1, AUTO_WAIT=0: each short cycle takes 3 clocks, each long cycle 5 clocks.
- Instruction length = Σ(3 or 5) + number of WAIT steps.
- Each WAIT step adds one step of latency. Minimum WAIT count per cycle = AUTO_WAIT.
- DONE_O is high for exactly one clock, the clock after the terminating step. It is not extended by STEP_I=0.
- Latched descriptors stay stable from cycle-0 T3 until instruction end. Input changes in later cycles have no effect.

## Test plan
- Reset, then NCYC_I=1, LONG_I=0, READY_I=1, STEP_I=1 → STATE_O repeats 010,100,001 with CYCLE_O=0; DONE_O high every 3rd clock.
- NCYC_I=3, LONG_I=3'b100 → cycle0 T1-T3, cycle1 T1-T3, cycle2 T1-T5 = 11 clocks; exactly one DONE_O pulse.
- READY_I=0 for 4 clocks from cycle-0 T2 → 4 WAIT clocks then T3. Separately, AUTO_WAIT=2 with READY_I=1 → exactly 2 WAIT states per cycle.
- HLT_I=1 at cycle-0 T3 → STOP held for 10 clocks. INT_I=1 → T1I, then INTA_O=1 through cycle-0 T3 and 0 afterwards.
- NCYC_I=3 with SKIP_I=1 at cycle-1 T3 → back to cycle 0 T1 after 6 clocks; DONE_O pulses once.
- STEP_I alternating 1/0 → STATE_O advances only after STEP_I=1 clocks. RST_I=1 during cycle-2 T4 → next clock STATE_O=010, CYCLE_O=0, INTA_O=0.
